alu_cmd_sequencer: RTL

Initiator-side controller for the 8-bit combinational ALU. It accepts ALU commands over a valid/ready stream and buffers them in a small FIFO. It drives A, B and select into the ALU one command at a time, registers result and flags, and returns them on a valid/ready response stream. An optional accumulator path lets a command take operand A from the previous result's low byte.

---
 rtl/alu_cmd_sequencer_pkg.sv | 36 +++
 rtl/alu_cmd_sequencer_fifo.sv | 84 ++++++++
 rtl/alu_cmd_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU command sequencer:
//   - ALU select/opcode width and the ADD..XOR opcode encodings
//   - operand (8-bit) and result (16-bit) widths
//   - the sequencer FSM state type (IDLE, EXEC, RESP)
//   - op_has_carry(): which opcodes produce a meaningful ALU carry
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int OP_W   = 4;
    localparam int DATA_W = 8;
    localparam int RES_W  = 16;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd2;
    localparam logic [OP_W-1:0] OP_AND  = 4'd3;
    localparam logic [OP_W-1:0] OP_OR   = 4'd4;
    localparam logic [OP_W-1:0] OP_NAND = 4'd5;
    localparam logic [OP_W-1:0] OP_NOR  = 4'd6;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // The ALU only drives its carry output for add and subtract; for every
    // other select it holds whatever it had before, so it must be masked.
    function automatic logic op_has_carry(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_fifo.sv
// -----------------------------------------------------------------------------
// alu_cmd_fifo
// Small synchronous FIFO holding queued ALU commands ({use_acc, op, b, a}).
// The head entry is visible combinationally on pop_data so the sequencer can
// pop and register the command in the same cycle.
//
// Parameters:
//   DEPTH  number of entries (power of 2, >= 2)
//   WIDTH  entry width in bits
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset (empties the FIFO)
//   push       write push_data at the tail (ignored when full unless popping)
//   push_data  entry to write
//   pop        remove the head entry (ignored when empty)
//   pop_data   current head entry
//   full       count == DEPTH
//   empty      count == 0
//   count      number of valid entries
// -----------------------------------------------------------------------------
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 21
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full     = (r_count == CW'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    // Storage carries no reset; validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
// Initiator-side controller for the 8-bit combinational ALU. Commands arrive
// on a valid/ready stream into a FIFO, are issued one at a time to the ALU,
// and the captured result/flags are returned on a valid/ready response stream.
// A command with use_acc set takes operand A from the low byte of the
// previous result.
//
// Optional feature (macro ALU_CMD_SEQ_ERR_EN):
//   defined   - opcodes with the top select bit set are not issued; they
//               produce an immediate error response (rsp_err=1, zero result
//               and flags) and leave acc and the alu_* outputs untouched.
//   undefined - rsp_err is tied low and every opcode is forwarded as-is.
//
// Parameters:
//   FIFO_DEPTH  command FIFO entries (power of 2, >= 2)
//   OP_W        select/opcode width (matches the ALU select port)
// Ports:
//   clk, rst_n                       clock / asynchronous active-low reset
//   cmd_valid, cmd_ready             command handshake (ready = FIFO not full)
//   cmd_op, cmd_a, cmd_b, cmd_use_acc command fields
//   alu_a, alu_b, alu_select         registered drive into the ALU
//   alu_result, alu_carry, alu_zflag ALU outputs
//   rsp_valid, rsp_ready             response handshake
//   rsp_result, rsp_carry, rsp_zflag captured ALU outputs
//   rsp_err                          illegal-opcode response (feature only)
//   busy                             FIFO non-empty or FSM not IDLE
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int OP_W       = alu_pkg::OP_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [OP_W-1:0]             cmd_op,
    input  logic [alu_pkg::DATA_W-1:0]  cmd_a,
    input  logic [alu_pkg::DATA_W-1:0]  cmd_b,
    input  logic                        cmd_use_acc,
    output logic [alu_pkg::DATA_W-1:0]  alu_a,
    output logic [alu_pkg::DATA_W-1:0]  alu_b,
    output logic [OP_W-1:0]             alu_select,
    input  logic [alu_pkg::RES_W-1:0]   alu_result,
    input  logic                        alu_carry,
    input  logic                        alu_zflag,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [alu_pkg::RES_W-1:0]   rsp_result,
    output logic                        rsp_carry,
    output logic                        rsp_zflag,
    output logic                        rsp_err,
    output logic                        busy
);

    import alu_pkg::*;

    localparam int CMD_W = 1 + OP_W + 2 * DATA_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t             r_state;
    logic               r_rdy;
    logic [DATA_W-1:0]  r_alu_a;
    logic [DATA_W-1:0]  r_alu_b;
    logic [OP_W-1:0]    r_alu_select;
    // Only the low byte of the previous result is ever fed back as operand A,
    // so that is all the accumulator keeps.
    logic [DATA_W-1:0]  r_acc;
    logic               r_rsp_valid;
    logic [RES_W-1:0]   r_rsp_result;
    logic               r_rsp_carry;
    logic               r_rsp_zflag;
`ifdef ALU_CMD_SEQ_ERR_EN
    logic               r_rsp_err;
`endif

    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;
    logic [CMD_W-1:0]   w_cmd_in;
    logic [CMD_W-1:0]   w_head;
    logic               w_head_use_acc;
    logic [OP_W-1:0]    w_head_op;
    logic [DATA_W-1:0]  w_head_a;
    logic [DATA_W-1:0]  w_head_b;
    logic [DATA_W-1:0]  w_issue_a;
    logic               w_can_load;

    // r_rdy is cleared by reset and set on the first clock after release, so
    // no command is accepted while rst_n is low.
    assign cmd_ready = r_rdy & ~w_full;
    assign w_push    = cmd_valid & cmd_ready;
    assign w_cmd_in  = {cmd_use_acc, cmd_op, cmd_b, cmd_a};

    assign {w_head_use_acc, w_head_op, w_head_b, w_head_a} = w_head;
    assign w_issue_a = w_head_use_acc ? r_acc : w_head_a;

    // The FSM may take the next command from IDLE, or from RESP in the cycle
    // the current response is handed off. Any non-EXEC/RESP encoding behaves
    // like IDLE so the machine cannot lock up.
    assign w_can_load = (r_state != EXEC) && ((r_state != RESP) || rsp_ready);
    assign w_pop      = w_can_load & ~w_empty;

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_cmd_in),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_rdy        <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_select <= '0;
            r_acc        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_zflag  <= 1'b0;
`ifdef ALU_CMD_SEQ_ERR_EN
            r_rsp_err    <= 1'b0;
`endif
        end else begin
            r_rdy <= 1'b1;
            case (r_state)
                EXEC: begin
                    // ALU inputs were registered last cycle; its outputs have
                    // settled and are captured here.
                    r_rsp_result <= alu_result;
                    r_rsp_zflag  <= alu_zflag;
                    r_rsp_carry  <= op_has_carry(r_alu_select) ? alu_carry : 1'b0;
                    r_acc        <= alu_result[DATA_W-1:0];
                    r_rsp_valid  <= 1'b1;
`ifdef ALU_CMD_SEQ_ERR_EN
                    r_rsp_err    <= 1'b0;
`endif
                    r_state      <= RESP;
                end
                default: begin
                    if (w_can_load) begin
                        r_rsp_valid <= 1'b0;
                        if (!w_empty) begin
`ifdef ALU_CMD_SEQ_ERR_EN
                            if (w_head_op[OP_W-1]) begin
                                // Illegal opcode: answer immediately without
                                // touching the ALU drive or the accumulator.
                                r_rsp_valid  <= 1'b1;
                                r_rsp_result <= '0;
                                r_rsp_carry  <= 1'b0;
                                r_rsp_zflag  <= 1'b0;
                                r_rsp_err    <= 1'b1;
                                r_state      <= RESP;
                            end else
`endif
                            begin
                                r_alu_a      <= w_issue_a;
                                r_alu_b      <= w_head_b;
                                r_alu_select <= w_head_op;
                                r_state      <= EXEC;
                            end
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_select = r_alu_select;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_carry  = r_rsp_carry;
    assign rsp_zflag  = r_rsp_zflag;
`ifdef ALU_CMD_SEQ_ERR_EN
    assign rsp_err    = r_rsp_err;
`else
    assign rsp_err    = 1'b0;
`endif
    assign busy       = (w_count != '0) || (r_state != IDLE);

endmodule
